hilo_div_sequencer: RTL and testbench

Multi-cycle divide sequencer that owns the HI/LO result path for DIV/DIVU. It accepts a divide from the execute stage and runs a radix-2 restoring division over 32 cycles. It then presents remainder/quotient for the writeback path, which feeds the decode stage's HasDivW/DivHiW/DivLoW inputs. It also raises a stall to the hazard unit whenever MFHI/MFLO or another divide would observe stale HI/LO.

---
 rtl/hilo_div_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_hilo_div_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_div_sequencer.sv
// ============================================================================
// Module   : hilo_div_sequencer
// Brief    : Radix-2 restoring DIV/DIVU sequencer owning the HI/LO result path,
//            with hazard stall. Signed support enabled by HILO_DIV_SIGNED_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hilo_div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             MfOpInD,
    input  logic             HasDivD,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] div_hi,
    output logic [WIDTH-1:0] div_lo
);

    localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [c_cnt_w-1:0] r_count;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvs;
    logic               r_done;
    logic               r_div_by_zero;
    logic [WIDTH-1:0]   r_div_hi;
    logic [WIDTH-1:0]   r_div_lo;

    logic               w_accept;
    logic               w_div_zero;
    logic               w_last;
    logic [WIDTH:0]     w_shift_rem;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH-1:0]   w_rem_step;
    logic [WIDTH-1:0]   w_quo_step;
    logic [WIDTH-1:0]   w_dvd_mag;
    logic [WIDTH-1:0]   w_dvs_mag;
    logic [WIDTH-1:0]   w_hi_final;
    logic [WIDTH-1:0]   w_lo_final;

    assign w_accept   = start & ((r_state == S_IDLE) | (r_state == S_DONE));
    assign w_div_zero = (divisor == '0);
    assign w_last     = (r_count == c_last);

    // One restoring step: the shifted remainder needs WIDTH+1 bits so the
    // trial subtraction's borrow lands in the top bit.
    assign w_shift_rem = {r_rem, r_quo[WIDTH-1]};
    assign w_trial     = w_shift_rem - {1'b0, r_dvs};
    assign w_rem_step  = w_trial[WIDTH] ? w_shift_rem[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign w_quo_step  = {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};

`ifdef HILO_DIV_SIGNED_EN
    logic w_dvd_neg;
    logic w_dvs_neg;
    logic r_q_neg;
    logic r_r_neg;

    assign w_dvd_neg  = is_signed & dividend[WIDTH-1];
    assign w_dvs_neg  = is_signed & divisor[WIDTH-1];
    assign w_dvd_mag  = w_dvd_neg ? -dividend : dividend;
    assign w_dvs_mag  = w_dvs_neg ? -divisor  : divisor;
    assign w_lo_final = r_q_neg ? -w_quo_step : w_quo_step;
    assign w_hi_final = r_r_neg ? -w_rem_step : w_rem_step;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
        end else if (w_accept && !w_div_zero) begin
            r_q_neg <= w_dvd_neg ^ w_dvs_neg;
            r_r_neg <= w_dvd_neg;
        end
    end
`else
    logic w_unused_is_signed;

    assign w_unused_is_signed = is_signed;
    assign w_dvd_mag  = dividend;
    assign w_dvs_mag  = divisor;
    assign w_lo_final = w_quo_step;
    assign w_hi_final = w_rem_step;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_next_state = w_div_zero ? S_DONE : S_RUN;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count       <= '0;
            r_rem         <= '0;
            r_quo         <= '0;
            r_dvs         <= '0;
            r_done        <= 1'b0;
            r_div_by_zero <= 1'b0;
            r_div_hi      <= '0;
            r_div_lo      <= '0;
        end else begin
            r_done        <= 1'b0;
            r_div_by_zero <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        if (w_div_zero) begin
                            r_done        <= 1'b1;
                            r_div_by_zero <= 1'b1;
                            r_div_lo      <= '1;
                            r_div_hi      <= dividend;
                        end else begin
                            r_rem   <= '0;
                            r_quo   <= w_dvd_mag;
                            r_dvs   <= w_dvs_mag;
                            r_count <= '0;
                        end
                    end
                end
                S_RUN: begin
                    r_rem   <= w_rem_step;
                    r_quo   <= w_quo_step;
                    r_count <= r_count + c_cnt_w'(1);
                    if (w_last) begin
                        r_div_hi <= w_hi_final;
                        r_div_lo <= w_lo_final;
                        r_done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = w_accept | (r_state == S_RUN);
    assign stall       = busy & (MfOpInD | HasDivD);
    assign done        = r_done;
    assign div_by_zero = r_div_by_zero;
    assign div_hi      = r_div_hi;
    assign div_lo      = r_div_lo;

endmodule

`default_nettype wire

// File: tb/tb_hilo_div_sequencer.sv
// ============================================================================
// Module   : tb_hilo_div_sequencer
// Brief    : Scoreboard bench for hilo_div_sequencer with a plain-arithmetic
//            reference model; honours HILO_DIV_SIGNED_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hilo_div_sequencer;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             is_signed = 1'b0;
    logic [WIDTH-1:0] dividend = '0;
    logic [WIDTH-1:0] divisor = '0;
    logic             MfOpInD = 1'b0;
    logic             HasDivD = 1'b0;
    logic             busy;
    logic             stall;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] div_hi;
    logic [WIDTH-1:0] div_lo;

    hilo_div_sequencer #(.WIDTH(WIDTH)) dut (
        .clock       (clk),
        .reset_n     (rst_n),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .MfOpInD     (MfOpInD),
        .HasDivD     (HasDivD),
        .busy        (busy),
        .stall       (stall),
        .done        (done),
        .div_by_zero (div_by_zero),
        .div_hi      (div_hi),
        .div_lo      (div_lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] lo;
        logic [WIDTH-1:0] hi;
        logic             dbz;
        int               cycle;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: truncating division on 64-bit integers, so the
    // most-negative / -1 case simply wraps when cut back to WIDTH bits.
    function automatic exp_t model(input bit sgn, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t   e;
        longint sa, sd, q, r;
        bit     use_s;
        e.cycle = 0;
        if (b == 0) begin
            e.lo  = '1;
            e.hi  = a;
            e.dbz = 1'b1;
            return e;
        end
`ifdef HILO_DIV_SIGNED_EN
        use_s = sgn;
`else
        use_s = 1'b0;
`endif
        sa = use_s ? longint'($signed(a)) : longint'(a);
        sd = use_s ? longint'($signed(b)) : longint'(b);
        q  = sa / sd;
        r  = sa % sd;
        e.lo  = q[WIDTH-1:0];
        e.hi  = r[WIDTH-1:0];
        e.dbz = 1'b0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
                mon_e = sb.pop_front();
                chk("div_lo", div_lo, mon_e.lo);
                chk("div_hi", div_hi, mon_e.hi);
                chk("div_by_zero", div_by_zero, mon_e.dbz);
                chk("done_cycle", cyc, mon_e.cycle);
            end
        end
    end

    task automatic drive_start(input bit sgn, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        e = model(sgn, a, b);
        e.cycle = cyc + ((b == 0) ? 1 : 33);
        sb.push_back(e);
        start     = 1'b1;
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
    endtask

    task automatic release_start();
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    task automatic issue(input bit sgn, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        drive_start(sgn, a, b);
        release_start();
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL done_timeout: got done=0 expected done=1 within 40 cycles");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] ra, rb;
        bit               rs;

        // Reset state while reset is held, with a hazard source present.
        MfOpInD = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", done, 0);
        chk("rst_div_by_zero", div_by_zero, 0);
        chk("rst_div_hi", div_hi, 0);
        chk("rst_div_lo", div_lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stall", stall, 0);
        MfOpInD = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(1'b0, 32'd100, 32'd7);
        wait_done();
        issue(1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_done();
        issue(1'b0, 32'h0000_1234, 32'd0);
        wait_done();
        @(posedge clk);
        #1;

        // Hazard stall across the whole divide, released in the DONE cycle.
        HasDivD = 1'b1;
        #1;
        chk("idle_hasdiv_stall", stall, 0);
        HasDivD = 1'b0;
        MfOpInD = 1'b1;
        drive_start(1'b0, 32'hDEAD_BEEF, 32'd13);
        #1;
        chk("stall_cycle0", stall, 1);
        release_start();
        for (int i = 1; i <= 32; i++) begin
            chk($sformatf("stall_cycle%0d", i), stall, 1);
            @(posedge clk);
            #1;
        end
        chk("stall_done_cycle", stall, 0);
        chk("done_at_33", done, 1);
        MfOpInD = 1'b0;
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a divide.
        issue(1'b0, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrun_busy", busy, 0);
        chk("midrun_done", done, 0);
        chk("midrun_div_hi", div_hi, 0);
        chk("midrun_div_lo", div_lo, 0);
        chk("midrun_div_by_zero", div_by_zero, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(1'b0, 32'd9, 32'd3);
        wait_done();

        // Overflow case, then a back-to-back start in its DONE cycle.
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done();
        issue(1'b0, 32'd55, 32'd5);
        wait_done();

        for (int k = 0; k < 24; k++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                3:       begin rb = $urandom; ra = 32'($urandom_range(0, 200)); end
                default: rb = $urandom;
            endcase
            issue(rs, ra, rb);
            wait_done();
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
